// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the frame generator and its sequencer.
// Pattern codes mirror the sel decoding in frame_pattern_gen.
package frame_gen_pkg;

  localparam int unsigned SEL_W     = 3;
  localparam int unsigned PAT_CODES = 1 << SEL_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } seq_state_e;

  localparam logic [SEL_W-1:0] PatColorBars  = 3'd0;
  localparam logic [SEL_W-1:0] PatRampH      = 3'd1;
  localparam logic [SEL_W-1:0] PatRampV      = 3'd2;
  localparam logic [SEL_W-1:0] PatChecker    = 3'd3;
  localparam logic [SEL_W-1:0] PatWalkOne    = 3'd4;
  localparam logic [SEL_W-1:0] PatSolidWhite = 3'd5;
  localparam logic [SEL_W-1:0] PatSolidBlack = 3'd6;
  localparam logic [SEL_W-1:0] PatPrbs       = 3'd7;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [PAT_CODES-1:0] mask);
    lowest_set = '0;
    for (int i = PAT_CODES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/frame_pat_next.sv
// Next enabled pattern code above cur, wrapping to the lowest enabled code.
// wrap is set whenever the search had to wrap (including a single-bit mask).
module frame_pat_next
  import frame_gen_pkg::*;
(
  input  logic [PAT_CODES-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  output logic [SEL_W-1:0]     nxt,
  output logic                 wrap
);

  always_comb begin
    nxt  = lowest_set(mask);
    wrap = 1'b1;
    // Descending scan so the last hit is the closest set bit above cur.
    for (int i = PAT_CODES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt  = SEL_W'(i);
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Sequences frame_gen through the enabled test patterns, holding each for a
// programmed number of frames; all changes land in the fval-low gap.
module frame_seq_ctrl
  import frame_gen_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned NUM_PAT     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop,
  input  logic [FRAME_CNT_W-1:0] frames_per_pat,
  input  logic [NUM_PAT-1:0]     pat_mask,
  input  logic                   fval,
  output logic                   en,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  seq_state_e             state_q, state_d;
  logic                   fval_d_q;
  logic                   en_q, en_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [FRAME_CNT_W-1:0] limit_q, limit_d;
  logic [PAT_CODES-1:0]   mask_q, mask_d;

  logic [PAT_CODES-1:0]   pat_mask_ext;
  logic [FRAME_CNT_W-1:0] frame_cnt_inc;
  logic [SEL_W-1:0]       nxt_sel;
  logic                   nxt_wrap;
  logic                   fe;

  assign pat_mask_ext  = PAT_CODES'(pat_mask);
  assign fe            = fval_d_q & ~fval;
  assign frame_cnt_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 1'b1;

  frame_pat_next u_pat_next (
    .mask (mask_q),
    .cur  (sel_q),
    .nxt  (nxt_sel),
    .wrap (nxt_wrap)
  );

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    sel_d       = sel_q;
    frame_cnt_d = frame_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    limit_d     = limit_q;
    mask_d      = mask_q;
    err_d       = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (pat_mask_ext == '0) begin
            err_d = 1'b1;
          end else begin
            mask_d      = pat_mask_ext;
            limit_d     = (frames_per_pat == '0) ? FRAME_CNT_W'(1) : frames_per_pat;
            sel_d       = lowest_set(pat_mask_ext);
            frame_cnt_d = '0;
            pat_cnt_d   = '0;
            en_d        = 1'b1;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (fe) begin
          frame_cnt_d = frame_cnt_inc;
          if (pat_cnt_q == limit_q - 1'b1) begin
            pat_cnt_d = '0;
            if (nxt_wrap && !loop) begin
              en_d    = 1'b0;
              state_d = StDone;
            end else begin
              sel_d = nxt_sel;
            end
          end else begin
            pat_cnt_d = pat_cnt_q + 1'b1;
          end
        end
        // A stop request freezes sel; an in-flight frame is drained first.
        if (abort) begin
          sel_d = sel_q;
          if (!fval) begin
            en_d    = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fe) begin
          frame_cnt_d = frame_cnt_inc;
          en_d        = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fval_d_q    <= 1'b0;
      en_q        <= 1'b0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      pat_cnt_q   <= '0;
      limit_q     <= FRAME_CNT_W'(1);
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      fval_d_q    <= fval;
      en_q        <= en_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      limit_q     <= limit_d;
      mask_q      <= mask_d;
    end
  end

  assign en        = en_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Self-checking bench for frame_seq_ctrl: a frame_gen fval model with random
// frame/gap lengths, a monitor, and a pattern-schedule reference model.
module tb_frame_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic [15:0] frames_per_pat = '0;
  logic [7:0]  pat_mask = '0;
  logic        fval = 1'b0;
  logic        en;
  logic [2:0]  sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  int obs_sel[$];
  int obs_cnt[$];
  int frames_seen = 0;
  int done_seen = 0;
  int sel_glitch = 0;

  frame_seq_ctrl #(
    .FRAME_CNT_W (16),
    .NUM_PAT     (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .loop           (loop),
    .frames_per_pat (frames_per_pat),
    .pat_mask       (pat_mask),
    .fval           (fval),
    .en             (en),
    .sel            (sel),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  // frame_gen stand-in: random active length, gap of at least 4 cycles.
  initial begin
    int act_len, gap_len, act_cnt, gap_cnt;
    act_len = 4; gap_len = 4; act_cnt = 0; gap_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        fval = 1'b0; act_cnt = 0; gap_cnt = 0;
      end else if (fval) begin
        act_cnt++;
        if (act_cnt >= act_len) begin
          fval = 1'b0; gap_cnt = 0;
        end
      end else begin
        gap_cnt++;
        if (en && gap_cnt >= gap_len) begin
          fval    = 1'b1;
          act_cnt = 0;
          act_len = $urandom_range(3, 10);
          gap_len = $urandom_range(4, 8);
        end
      end
    end
  end

  initial begin
    logic       fval_prev;
    logic [2:0] sel_prev;
    fval_prev = 1'b0; sel_prev = '0;
    forever begin
      @(negedge clk);
      if (fval && !fval_prev) begin
        obs_sel.push_back(int'(sel));
        obs_cnt.push_back(int'(frame_cnt));
      end
      if (fval && fval_prev && sel != sel_prev) sel_glitch++;
      if (fval_prev && !fval) frames_seen++;
      if (done === 1'b1) done_seen++;
      fval_prev = fval;
      sel_prev  = sel;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1);
  end

  // Reference: frame k shows the (k / limit)-th enabled code, cycling.
  function automatic int exp_sel(input logic [7:0] m, input int fpp, input int k);
    int pats[$];
    int lim;
    for (int i = 0; i < 8; i++) if (m[i]) pats.push_back(i);
    lim = (fpp == 0) ? 1 : fpp;
    return pats[(k / lim) % pats.size()];
  endfunction

  function automatic int run_len(input logic [7:0] m, input int fpp);
    return $countones(m) * ((fpp == 0) ? 1 : fpp);
  endfunction

  function automatic int lowest_bit(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic clear_mon();
    obs_sel.delete();
    obs_cnt.delete();
    frames_seen = 0;
    done_seen   = 0;
    sel_glitch  = 0;
  endtask

  task automatic do_start(input logic [7:0] m, input int f, input logic l);
    @(negedge clk);
    pat_mask = m; frames_per_pat = 16'(f); loop = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_started(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (obs_sel.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_ended(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (frames_seen >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %0b want 0", en); end
    vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL reset_sel got %0d want 0", sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL reset_done_err got %0b%0b want 00", done, err);
    end
    vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pass();
    bit ok;
    clear_mon();
    do_start(8'h05, 2, 1'b0);
    vectors++; if (en !== 1'b1 || sel !== 3'd0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL start_latency got en=%0b sel=%0d busy=%0b want 1 0 1", en, sel, busy);
    end
    wait_done(600, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pass_done_timeout got no done want done"); end
    vectors++; if (en !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL pass_done_cycle got en=%0b busy=%0b want 0 0", en, busy);
    end
    repeat (3) @(negedge clk);
    vectors++; if (obs_sel.size() != 4) begin
      miscompares++; $display("FAIL pass_frames got %0d want 4", obs_sel.size());
    end
    for (int k = 0; k < obs_sel.size() && k < 4; k++) begin
      vectors++; if (obs_sel[k] != exp_sel(8'h05, 2, k) || obs_cnt[k] != k) begin
        miscompares++;
        $display("FAIL pass_frame%0d got sel=%0d cnt=%0d want sel=%0d cnt=%0d",
                 k, obs_sel[k], obs_cnt[k], exp_sel(8'h05, 2, k), k);
      end
    end
    vectors++; if (frame_cnt !== 16'd4 || done_seen != 1 || sel_glitch != 0) begin
      miscompares++;
      $display("FAIL pass_end got cnt=%0d dones=%0d glitches=%0d want 4 1 0", frame_cnt, done_seen, sel_glitch);
    end
  endtask

  task automatic test_single_pat_loop();
    bit ok;
    clear_mon();
    do_start(8'h80, 0, 1'b1);
    wait_ended(3, 400, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL loop1_timeout got %0d frames want 3", frames_seen); end
    wait_done(50, ok);
    vectors++; if (!ok || obs_sel.size() != 3) begin
      miscompares++; $display("FAIL loop1_end got done=%0b frames=%0d want 1 3", ok, obs_sel.size());
    end
    for (int k = 0; k < obs_sel.size(); k++) begin
      vectors++; if (obs_sel[k] != 7 || obs_cnt[k] != k) begin
        miscompares++; $display("FAIL loop1_frame%0d got sel=%0d cnt=%0d want 7 %0d", k, obs_sel[k], obs_cnt[k], k);
      end
    end
    vectors++; if (frame_cnt !== 16'd3) begin miscompares++; $display("FAIL loop1_cnt got %0d want 3", frame_cnt); end
  endtask

  task automatic test_abort_drain();
    bit ok, bad;
    int cyc, fpp;
    logic [7:0] m;
    m   = 8'($urandom_range(1, 255));
    fpp = $urandom_range(1, 3);
    clear_mon();
    do_start(m, fpp, 1'b1);
    wait_started(2, 400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL abort_wait got %0d frames want 2", obs_sel.size()); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b0;
    bad = 1'b0; cyc = 0;
    while (fval === 1'b1 && cyc < 50) begin
      if (en !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    vectors++; if (bad || cyc >= 50) begin
      miscompares++; $display("FAIL abort_drain_hold got dropped=%0b cycles=%0d want 0 <50", bad, cyc);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (en !== 1'b0 || frame_cnt !== 16'd2) begin
      miscompares++; $display("FAIL abort_stop got en=%0b cnt=%0d want 0 2", en, frame_cnt);
    end
    repeat (5) @(negedge clk);
    vectors++; if (done_seen != 1 || busy !== 1'b0 || obs_sel.size() != 2) begin
      miscompares++;
      $display("FAIL abort_done got dones=%0d busy=%0b frames=%0d want 1 0 2", done_seen, busy, obs_sel.size());
    end
    vectors++; if (obs_sel.size() >= 2 && obs_sel[1] != exp_sel(m, fpp, 1)) begin
      miscompares++; $display("FAIL abort_sel got %0d want %0d", obs_sel[1], exp_sel(m, fpp, 1));
    end
  endtask

  task automatic test_boundary();
    clear_mon();
    do_start(8'h00, 1, 1'b0);
    vectors++; if (err !== 1'b1 || busy !== 1'b0 || en !== 1'b0) begin
      miscompares++; $display("FAIL zero_mask got err=%0b busy=%0b en=%0b want 1 0 0", err, busy, en);
    end
    @(negedge clk);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL zero_mask_pulse got err=%0b want 0", err); end
    pat_mask = 8'h0f; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b0 || en !== 1'b0 || obs_sel.size() != 0 || done_seen != 0) begin
      miscompares++;
      $display("FAIL start_abort got busy=%0b en=%0b frames=%0d dones=%0d want 0 0 0 0",
               busy, en, obs_sel.size(), done_seen);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int d0;
    logic [7:0] m;
    clear_mon();
    do_start(8'h6c, 1, 1'b1);
    wait_started(2, 400, ok);
    vectors++; if (!ok || frame_cnt !== 16'd1) begin
      miscompares++; $display("FAIL rst_setup got frames=%0d cnt=%0d want 2 1", obs_sel.size(), frame_cnt);
    end
    d0 = done_seen;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if ({en, busy, done, err} !== 4'b0 || sel !== 3'd0 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_async got en=%0b busy=%0b done=%0b err=%0b sel=%0d cnt=%0d want all 0",
               en, busy, done, err, sel, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (done_seen != d0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_no_done got dones=%0d busy=%0b want %0d 0", done_seen, busy, d0);
    end
    m = 8'($urandom_range(1, 255));
    clear_mon();
    do_start(m, 1, 1'b0);
    vectors++; if (sel !== 3'(lowest_bit(m)) || frame_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rst_restart got sel=%0d cnt=%0d want %0d 0", sel, frame_cnt, lowest_bit(m));
    end
    wait_done(600, ok);
    repeat (2) @(negedge clk);
    vectors++; if (!ok || frame_cnt !== 16'(run_len(m, 1)) || obs_sel.size() != run_len(m, 1)) begin
      miscompares++;
      $display("FAIL rst_rerun got done=%0b cnt=%0d frames=%0d want 1 %0d", ok, frame_cnt, obs_sel.size(), run_len(m, 1));
    end
  endtask

  task automatic test_two_pat_loop();
    bit ok;
    int want[5];
    want = '{1, 4, 1, 4, 1};
    clear_mon();
    do_start(8'h12, 1, 1'b1);
    wait_ended(5, 600, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(50, ok);
    vectors++; if (!ok || obs_sel.size() != 5 || frame_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL two_pat_end got done=%0b frames=%0d cnt=%0d want 1 5 5", ok, obs_sel.size(), frame_cnt);
    end
    for (int k = 0; k < obs_sel.size() && k < 5; k++) begin
      vectors++; if (obs_sel[k] != want[k]) begin
        miscompares++; $display("FAIL two_pat_frame%0d got %0d want %0d", k, obs_sel[k], want[k]);
      end
    end
    vectors++; if (sel_glitch != 0) begin
      miscompares++; $display("FAIL two_pat_gap got %0d in-frame sel changes want 0", sel_glitch);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int fpp, n;
    logic [7:0] m;
    for (int r = 0; r < 4; r++) begin
      m   = 8'($urandom_range(1, 255));
      fpp = $urandom_range(0, 3);
      n   = run_len(m, fpp);
      clear_mon();
      do_start(m, fpp, 1'b0);
      wait_started(1, 400, ok);
      // A start while busy must not disturb the run.
      pat_mask = ~m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2000, ok);
      repeat (2) @(negedge clk);
      vectors++; if (!ok || obs_sel.size() != n || frame_cnt !== 16'(n) || done_seen != 1) begin
        miscompares++;
        $display("FAIL b2b%0d_end got done=%0b frames=%0d cnt=%0d dones=%0d want 1 %0d %0d 1",
                 r, ok, obs_sel.size(), frame_cnt, done_seen, n, n);
      end
      for (int k = 0; k < obs_sel.size() && k < n; k++) begin
        vectors++; if (obs_sel[k] != exp_sel(m, fpp, k) || obs_cnt[k] != k) begin
          miscompares++;
          $display("FAIL b2b%0d_frame%0d got sel=%0d cnt=%0d want sel=%0d cnt=%0d",
                   r, k, obs_sel[k], obs_cnt[k], exp_sel(m, fpp, k), k);
        end
      end
      vectors++; if (sel_glitch != 0 || err_during_run_check()) begin
        miscompares++; $display("FAIL b2b%0d_gap got %0d in-frame sel changes want 0", r, sel_glitch);
      end
    end
  endtask

  function automatic bit err_during_run_check();
    return err === 1'b1;
  endfunction

  initial begin
    test_reset();
    test_single_pass();
    test_single_pat_loop();
    test_abort_drain();
    test_boundary();
    test_reset_mid_run();
    test_two_pat_loop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
